shared_reg_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit D register between N_REQ requesters.
- Grants exactly one requester at a time and loads that requester's data into the register while it holds the grant.
- Supports an optional lock that extends a grant, bounded by MAX_HOLD cycles.
- Sits between lab datapath producers and the common storage register.

---
 rtl/shared_reg_arbiter_pkg.sv | 19 +
 rtl/shared_reg_arbiter_if.sv | 30 +++
 rtl/shared_reg_arbiter_rr_pick.sv | 42 ++++
 rtl/shared_reg_arbiter.sv | 116 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: state encoding,
// index-width helper and default parameter values.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter. The master modport is
// the requester cluster; the slave modport is the arbiter itself.
interface shared_reg_arbiter_if #(
    parameter int N_REQ = arb_pkg::DEF_N_REQ,
    parameter int WIDTH = arb_pkg::DEF_WIDTH
);
    import arb_pkg::*;

    localparam int OW = idx_w(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [OW-1:0]          owner;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic                   upd;

    modport master (
        output req, lock, wdata,
        input  gnt, owner, busy, q, upd
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, owner, busy, q, upd
    );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Cyclic priority search: returns the first set request at or after ptr,
// wrapping around, and whether any request was set at all.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] shifted;
    logic [N_REQ-1:0]   rot;

    // Rotate the request vector so that bit 0 is the requester at ptr.
    assign dbl     = {req, req};
    assign shifted = dbl >> ptr;
    assign rot     = shifted[N_REQ-1:0];

    // Take the nearest set bit of the rotated vector and map it back.
    always_comb begin
        int s;
        found = 1'b0;
        idx   = '0;
        s     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                s     = int'(ptr) + k;
                if (s >= N_REQ) begin
                    s = s - N_REQ;
                end
                idx = IW'(s);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register between N_REQ
// requesters. Each grant lasts one BUSY cycle, or longer while the owner
// keeps req and lock high, up to MAX_HOLD cycles. Grants are always
// separated by one IDLE cycle.
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input logic                 clk,
    input logic                 reset,
    shared_reg_arbiter_if.slave bus
);

    localparam int OW = idx_w(N_REQ);
    localparam int HW = idx_w(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [OW-1:0] LAST_IDX   = OW'(N_REQ - 1);

    state_t             state, state_nx;
    logic [N_REQ-1:0]   gnt, gnt_nx;
    logic [OW-1:0]      owner, owner_nx;
    logic [OW-1:0]      ptr, ptr_nx;
    logic [HW-1:0]      hcnt, hcnt_nx;
    logic [WIDTH-1:0]   q, q_nx;
    logic               upd, upd_nx;

    logic               pick_found;
    logic [OW-1:0]      pick_idx;
    logic               own_req;
    logic               own_lock;
    logic [WIDTH-1:0]   own_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (OW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign own_req  = bus.req[owner];
    assign own_lock = bus.lock[owner];
    assign own_data = bus.wdata[owner*WIDTH +: WIDTH];

    // State and datapath registers; reset also clears the shared register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            hcnt  <= '0;
            q     <= '0;
            upd   <= 1'b0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            hcnt  <= hcnt_nx;
            q     <= q_nx;
            upd   <= upd_nx;
        end
    end

    // Grant selection in IDLE; write, hold counting and release in BUSY.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        owner_nx = owner;
        ptr_nx   = ptr;
        hcnt_nx  = hcnt;
        q_nx     = q;
        upd_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_nx = '0;
                if (pick_found) begin
                    state_nx = BUSY;
                    gnt_nx   = N_REQ'(1) << pick_idx;
                    owner_nx = pick_idx;
                    hcnt_nx  = HW'(1);
                end
            end
            BUSY: begin
                if (own_req) begin
                    q_nx   = own_data;
                    upd_nx = 1'b1;
                end
                if (!own_req || !own_lock || (hcnt == HOLD_LIMIT)) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    ptr_nx   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end else begin
                    hcnt_nx = hcnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    assign bus.gnt   = gnt;
    assign bus.owner = owner;
    assign bus.busy  = (state == BUSY);
    assign bus.q     = q;
    assign bus.upd   = upd;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a tenure-level reference model.
module tb_shared_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MH = 8;

    logic clk;
    logic reset;

    shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    shared_reg_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .MAX_HOLD (MH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: who currently holds the register (or nobody), how
    // long they have held it, where the next search starts, and what the
    // register holds.
    bit             m_held;
    int             m_owner;
    int             m_tenure;
    int             m_next;
    logic [W-1:0]   m_q;
    bit             m_upd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] data_of(input int i);
        logic [N*W-1:0] v;
        v = bus.wdata;
        return v[i*W +: W];
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_held = 0; m_owner = 0; m_tenure = 0; m_next = 0; m_q = '0; m_upd = 0;
        end else if (!m_held) begin
            m_upd = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_next + k) % N;
                if (!m_held && bus.req[c]) begin
                    m_held = 1; m_owner = c; m_tenure = 1;
                end
            end
        end else begin
            bit wants;
            wants = bus.req[m_owner];
            m_upd = wants;
            if (wants) m_q = data_of(m_owner);
            if (!wants || !bus.lock[m_owner] || m_tenure >= MH) begin
                m_held = 0;
                m_next = (m_owner + 1) % N;
            end else begin
                m_tenure++;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        logic [N-1:0] eg;
        eg = m_held ? N'(1) << m_owner : '0;
        chk({ph, ".gnt"},   32'(bus.gnt),   32'(eg));
        chk({ph, ".owner"}, 32'(bus.owner), 32'(m_owner));
        chk({ph, ".busy"},  32'(bus.busy),  32'(m_held));
        chk({ph, ".q"},     32'(bus.q),     32'(m_q));
        chk({ph, ".upd"},   32'(bus.upd),   32'(m_upd));
    endtask

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        bus.wdata[i*W +: W] = v;
    endtask

    initial begin
        int gcnt;
        int ucnt;
        reset     = 1'b1;
        bus.req   = '1;
        bus.lock  = '0;
        bus.wdata = '0;
        m_held = 0; m_owner = 0; m_tenure = 0; m_next = 0; m_q = '0; m_upd = 0;
        @(negedge clk);

        // Reset held with every requester asking.
        step("rst");
        step("rst");
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_q",   32'(bus.q),   32'h0);
        reset = 1'b0;
        step("first");
        chk("first_gnt", 32'(bus.gnt), 32'b0001);

        // Single unlocked request from requester 2.
        bus.req = '0;
        step("drain");
        step("drain");
        bus.req = 4'b0100;
        set_data(2, 4'hA);
        step("single");
        chk("single_gnt", 32'(bus.gnt), 32'b0100);
        step("single");
        chk("single_q",   32'(bus.q),   32'hA);
        chk("single_upd", 32'(bus.upd), 32'h1);
        chk("single_rel", 32'(bus.busy), 32'h0);
        bus.req = '0;
        step("single");
        bus.req = 4'b1001;
        step("ptr3");
        chk("ptr3_owner", 32'(bus.owner), 32'h3);

        // Full rotation from a fresh pointer.
        reset = 1'b1;
        step("rst2");
        reset = 1'b0;
        bus.req = '1;
        bus.wdata = {4'h4, 4'h3, 4'h2, 4'h1};
        for (int g = 0; g < 5; g++) begin
            step("rot");
            chk("rot_owner", 32'(bus.owner), 32'(g % N));
            step("rot");
            chk("rot_q", 32'(bus.q), 32'((g % N) + 1));
        end

        // Locked requester 1 forced off after MAX_HOLD cycles.
        bus.req = '0;
        step("drain");
        step("drain");
        bus.req  = 4'b1010;
        bus.lock = 4'b0010;
        gcnt = 0;
        ucnt = 0;
        for (int s = 0; s < MH + 2; s++) begin
            set_data(1, W'(s + 1));
            step("hold");
            gcnt += int'(bus.gnt[1]);
            ucnt += int'(bus.upd);
        end
        chk("hold_gnt_cycles", 32'(gcnt), 32'(MH));
        chk("hold_upd_pulses", 32'(ucnt), 32'(MH));
        chk("hold_next_owner", 32'(bus.owner), 32'h3);

        // Locked owner 2 drops its request in the third BUSY cycle.
        bus.req  = '0;
        bus.lock = '0;
        step("drain");
        step("drain");
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        set_data(2, 4'h5);
        step("drop");
        step("drop");
        set_data(2, 4'h6);
        step("drop");
        bus.req = '0;
        set_data(2, 4'hF);
        step("drop");
        chk("drop_q",    32'(bus.q),    32'h6);
        chk("drop_upd",  32'(bus.upd),  32'h0);
        chk("drop_busy", 32'(bus.busy), 32'h0);

        // Reset lands on a BUSY cycle that would have written.
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        set_data(2, 4'h9);
        step("abort");
        step("abort");
        reset = 1'b1;
        set_data(2, 4'hC);
        step("abort");
        chk("abort_q",    32'(bus.q),    32'h0);
        chk("abort_gnt",  32'(bus.gnt),  32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        bus.req  = 4'b1001;
        bus.lock = '0;
        step("abort_ptr");
        chk("abort_ptr_owner", 32'(bus.owner), 32'h0);

        // Random traffic.
        for (int r = 0; r < 400; r++) begin
            bus.req   = N'($urandom);
            bus.lock  = N'($urandom) | N'($urandom);
            bus.wdata = (N*W)'($urandom);
            reset     = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
